mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_wait_timer.sv | 33 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory arbiter: FSM state
// encoding, request-owner encoding and the default access timeout.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam int TIMEOUT_DEF = 15;
   localparam int TMR_W       = 8;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Access watchdog: counts cycles while enabled and flags the cycle in which
// the TIMEOUT-th enabled cycle is being spent.
module wait_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

   logic [TMR_W-1:0] cnt;

   // Cycle counter, cleared whenever the owner is not inside an access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + TMR_W'(1);
      end
   end

   // Leaving on this edge makes the count reach TIMEOUT exactly.
   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory.
// One transaction at a time: IDLE grants, ACCESS drives the memory until it
// is ready or the watchdog expires, RESP pulses ack or err to the owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy
);

   logic [1:0] state;
   logic       owner;
   logic       last_own;
   logic       lat_we;
   logic       err_flag;
   logic       grant_own;
   logic       in_access;
   logic       expired;

   assign in_access = (state == ST_ACCESS);

   // Round-robin pick: on a tie the port not served last wins.
   always_comb begin
      grant_own = OWN_IF;
      if (if_req && d_req) begin
         grant_own = ~last_own;
      end else if (d_req) begin
         grant_own = OWN_D;
      end
   end

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_access),
      .en      (in_access),
      .expired (expired)
   );

   // Transaction FSM plus the latched request (address/data live directly in the output registers).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         owner     <= OWN_IF;
         last_own  <= OWN_D;
         lat_we    <= 1'b0;
         err_flag  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (if_req || d_req) begin
                  state     <= ST_ACCESS;
                  owner     <= grant_own;
                  last_own  <= grant_own;
                  lat_we    <= (grant_own == OWN_D) && d_we;
                  err_flag  <= 1'b0;
                  mem_addr  <= (grant_own == OWN_D) ? d_addr : if_addr;
                  mem_wdata <= (grant_own == OWN_D) ? d_wdata : '0;
               end
            end
            ST_ACCESS: begin
               // A ready arriving in the last allowed cycle still counts as success.
               if (mem_ready) begin
                  state    <= ST_RESP;
                  err_flag <= 1'b0;
               end else if (expired) begin
                  state    <= ST_RESP;
                  err_flag <= 1'b1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read-data capture; stores and timeouts leave both registers untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rdata <= '0;
         d_rdata  <= '0;
      end else if (in_access && mem_ready) begin
         if (owner == OWN_IF) begin
            if_rdata <= mem_rdata;
         end else if (!lat_we) begin
            d_rdata <= mem_rdata;
         end
      end
   end

   assign mem_en = in_access;
   assign mem_we = in_access && lat_we;
   assign busy   = (state != ST_IDLE);
   assign if_ack = (state == ST_RESP) && (owner == OWN_IF) && !err_flag;
   assign if_err = (state == ST_RESP) && (owner == OWN_IF) && err_flag;
   assign d_ack  = (state == ST_RESP) && (owner == OWN_D) && !err_flag;
   assign d_err  = (state == ST_RESP) && (owner == OWN_D) && err_flag;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of request rows served by a
// small memory responder, with expected transactions queued at drive time
// and popped when the arbiter pulses ack/err; plus reset and stray-ready
// sequences.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int TO    = 15;
   localparam int NEVER = 99;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          if_ack, if_err, d_ack, d_err;
   logic          mem_en, mem_we, mem_ready, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .if_err    (if_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .d_err     (d_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .busy      (busy)
   );

   typedef struct {
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            lat;
   } exp_t;

   typedef struct {
      logic          if_v;
      logic [AW-1:0] if_a;
      int            if_lat;
      logic [DW-1:0] if_mem;
      logic          d_v;
      logic          d_w;
      logic [AW-1:0] d_a;
      logic [DW-1:0] d_wd;
      int            d_lat;
      logic [DW-1:0] d_mem;
      logic          first;
      logic [DW-1:0] exp_if_rd;
      logic [DW-1:0] exp_d_rd;
   } row_t;

   exp_t sb[$];
   row_t rows[8];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_row(input int id, input row_t r);
      exp_t       e, e_if, e_d;
      int         encnt;
      logic       exp_err, first_done;
      logic [3:0] pulses, exp_p;
      e_if.port = OWN_IF; e_if.we = 1'b0;  e_if.addr = r.if_a; e_if.wdata = '0;     e_if.lat = r.if_lat;
      e_d.port  = OWN_D;  e_d.we  = r.d_w; e_d.addr  = r.d_a;  e_d.wdata  = r.d_wd; e_d.lat  = r.d_lat;
      if (r.if_v && r.d_v) begin
         if (r.first == OWN_IF) begin sb.push_back(e_if); sb.push_back(e_d); end
         else                   begin sb.push_back(e_d);  sb.push_back(e_if); end
      end else if (r.if_v) begin
         sb.push_back(e_if);
      end else if (r.d_v) begin
         sb.push_back(e_d);
      end
      @(negedge clk);
      if_req = r.if_v; if_addr = r.if_a;
      d_req  = r.d_v;  d_we = r.d_w; d_addr = r.d_a; d_wdata = r.d_wd;
      encnt = 0;
      first_done = 1'b0;
      for (int cyc = 0; cyc < 100 && sb.size() != 0; cyc++) begin
         @(negedge clk);
         pulses = {if_ack, if_err, d_ack, d_err};
         if (pulses != 4'b0000) begin
            e = sb.pop_front();
            exp_err = (e.lat >= TO);
            exp_p = (e.port == OWN_IF) ? {!exp_err, exp_err, 2'b00} : {2'b00, !exp_err, exp_err};
            chk($sformatf("row%0d pulse{ia,ie,da,de}", id), pulses, exp_p);
            chk($sformatf("row%0d mem_en_cycles", id), encnt, exp_err ? TO : e.lat + 1);
            chk($sformatf("row%0d mem_en_in_resp", id), mem_en, 1'b0);
            if (!first_done) chk($sformatf("row%0d latency", id), cyc, exp_err ? TO : e.lat + 1);
            first_done = 1'b1;
            if (e.port == OWN_IF) if_req = 1'b0; else d_req = 1'b0;
            encnt = 0;
         end
         if (mem_en && sb.size() != 0) begin
            encnt++;
            if (encnt == 1) begin
               chk($sformatf("row%0d mem_addr", id), mem_addr, sb[0].addr);
               chk($sformatf("row%0d mem_we", id), mem_we, (sb[0].port == OWN_D) && sb[0].we);
               if (sb[0].we) chk($sformatf("row%0d mem_wdata", id), mem_wdata, sb[0].wdata);
            end
            mem_ready = (encnt > sb[0].lat);
            mem_rdata = (sb[0].port == OWN_IF) ? r.if_mem : r.d_mem;
         end else begin
            mem_ready = 1'b0;
         end
      end
      if (sb.size() != 0) begin
         chk($sformatf("row%0d completion_budget", id), sb.size(), 0);
         sb.delete();
         if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("row%0d busy_after", id), busy, 1'b0);
      chk($sformatf("row%0d no_extra_pulse", id), {if_ack, if_err, d_ack, d_err}, 4'b0000);
      chk($sformatf("row%0d if_rdata", id), if_rdata, r.exp_if_rd);
      chk($sformatf("row%0d d_rdata", id), d_rdata, r.exp_d_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t r8;
      //          if_v  if_a     if_lat if_mem        d_v   d_w   d_a       d_wd          d_lat d_mem         first   exp_if_rd     exp_d_rd
      rows[0] = '{1'b1, 32'h40,  0,     32'h8C01_0004, 1'b1, 1'b0, 32'h200,  32'h0,        1,    32'h1111_2222, OWN_IF, 32'h8C01_0004, 32'h1111_2222};
      rows[1] = '{1'b1, 32'h44,  2,     32'h3333_4444, 1'b0, 1'b0, 32'h0,    32'h0,        0,    32'h0,         OWN_IF, 32'h3333_4444, 32'h1111_2222};
      rows[2] = '{1'b1, 32'h48,  0,     32'h5555_6666, 1'b1, 1'b1, 32'h100,  32'hDEAD_BEEF, 0,   32'hFFFF_FFFF, OWN_D,  32'h5555_6666, 32'h1111_2222};
      rows[3] = '{1'b0, 32'h0,   0,     32'h0,         1'b1, 1'b0, 32'h204,  32'h0,        0,    32'h9999_AAAA, OWN_D,  32'h5555_6666, 32'h9999_AAAA};
      rows[4] = '{1'b1, 32'h4C,  1,     32'h7777_8888, 1'b1, 1'b0, 32'h300,  32'h0,        NEVER, 32'h0,        OWN_IF, 32'h7777_8888, 32'h9999_AAAA};
      rows[5] = '{1'b1, 32'h50,  NEVER, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        0,    32'h0,         OWN_IF, 32'h7777_8888, 32'h9999_AAAA};
      rows[6] = '{1'b0, 32'h0,   0,     32'h0,         1'b1, 1'b0, 32'h208,  32'h0,        14,   32'h0BAD_F00D, OWN_D,  32'h7777_8888, 32'h0BAD_F00D};
      rows[7] = '{1'b0, 32'h0,   0,     32'h0,         1'b1, 1'b1, 32'h104,  32'h1234_5678, 3,   32'hFFFF_FFFF, OWN_D,  32'h7777_8888, 32'h0BAD_F00D};

      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("reset mem_en", mem_en, 1'b0);
      chk("reset mem_we", mem_we, 1'b0);
      chk("reset mem_addr", mem_addr, '0);
      chk("reset mem_wdata", mem_wdata, '0);
      chk("reset if_rdata", if_rdata, '0);
      chk("reset d_rdata", d_rdata, '0);
      chk("reset pulses", {if_ack, if_err, d_ack, d_err}, 4'b0000);
      chk("reset busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset busy", busy, 1'b0);

      for (int i = 0; i < 8; i++) run_row(i, rows[i]);

      // Stray mem_ready while idle must be ignored.
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stray%0d pulses", k), {if_ack, if_err, d_ack, d_err}, 4'b0000);
         chk($sformatf("stray%0d busy", k), busy, 1'b0);
         chk($sformatf("stray%0d if_rdata", k), if_rdata, 32'h7777_8888);
         chk($sformatf("stray%0d d_rdata", k), d_rdata, 32'h0BAD_F00D);
      end
      mem_ready = 1'b0;

      // Reset in the middle of a fetch aborts it silently.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h60;
      repeat (3) @(negedge clk);
      chk("midrst mem_en_before", mem_en, 1'b1);
      rst_n = 1'b0;
      if_req = 1'b0;
      #1;
      chk("midrst mem_en_async", mem_en, 1'b0);
      chk("midrst busy_async", busy, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("midrst%0d pulses", k), {if_ack, if_err, d_ack, d_err}, 4'b0000);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst pulses_after", {if_ack, if_err, d_ack, d_err}, 4'b0000);
      chk("midrst if_rdata_cleared", if_rdata, '0);
      r8 = '{1'b1, 32'h60, 1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, OWN_IF, 32'hCAFE_0001, 32'h0};
      run_row(8, r8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
